ats21_cmd_driver: RTL

Host-side command driver for one control channel of the alarm/timer block. It accepts 32-bit commands from a host over a valid/ready interface and buffers them in a small FIFO. It serialises each command as two 16-bit beats (upper half first) onto the `ctrl`/`req`/`ready` port, and captures rising edges on the 24 alarm/timer outputs into sticky event flags. The block is instantiated once per channel (A and B).

---
 rtl/ats21_cmd_driver.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/ats21_cmd_driver.sv
// rtl/ats21_cmd_driver.sv - host command FIFO, two-beat serialiser and alarm edge capture
//
// Ports:
//   clk, reset         clock; synchronous active-high reset
//   cmd_valid/ready    host command handshake (cmd_ready = !full)
//   cmd_data[31:0]     command word, [31:29] opcode (3'b100 is illegal)
//   ctrl[15:0], req    registered beat data/valid to target
//   ready              target accepts beat
//   busy               FIFO non-empty or a command is in flight
//   illegal_cnt        saturating count of discarded illegal commands
//   alarm_in           alarm/timer outputs from target
//   alarm_clr          per-bit clear of the sticky flags
//   alarm_evt          sticky rising-edge flags
module ats21_cmd_driver #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    input  logic [31:0]      cmd_data,
    output logic             cmd_ready,
    output logic [15:0]      ctrl,
    output logic             req,
    input  logic             ready,
    output logic             busy,
    output logic [CNT_W-1:0] illegal_cnt,
    input  logic [23:0]      alarm_in,
    input  logic [23:0]      alarm_clr,
    output logic [23:0]      alarm_evt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0] ONE_CNT  = (AW + 1)'(1);

    typedef enum logic [1:0] {IDLE, HI, LO} state_t;

    state_t          state;
    logic [31:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   rd_ptr_nx;
    logic [AW:0]     count;
    logic            full;
    logic            empty;
    logic            accept;
    logic            is_illegal;
    logic            push;
    logic            pop;
    logic            more_after_pop;
    logic [15:0]     next_hi;
    logic [23:0]     alarm_q;
    logic [23:0]     rise;

    assign full       = (count == FULL_CNT);
    assign empty      = (count == '0);
    assign cmd_ready  = !full;
    assign accept     = cmd_valid && cmd_ready;
    assign is_illegal = (cmd_data[31:29] == 3'b100);
    assign push       = accept && !is_illegal;
    assign pop        = (state == LO) && ready;
    assign busy       = !empty || (state != IDLE);
    assign rd_ptr_nx  = rd_ptr + AW'(1);

    // When the last stored entry pops while a new word is pushed on the same
    // edge, forward the incoming word so req stays high without a gap.
    assign more_after_pop = (count > ONE_CNT) || push;
    assign next_hi        = (count > ONE_CNT) ? mem[rd_ptr_nx][31:16] : cmd_data[31:16];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= cmd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr_nx;
            case ({push, pop})
                2'b10:   count <= count + ONE_CNT;
                2'b01:   count <= count - ONE_CNT;
                default: count <= count;
            endcase
        end
    end

    // Head entry stays in the FIFO until its lower beat transfers, so the
    // lower half is read straight from mem[rd_ptr] while in HI.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            req   <= 1'b0;
            ctrl  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    req <= 1'b0;
                    if (!empty) begin
                        ctrl  <= mem[rd_ptr][31:16];
                        req   <= 1'b1;
                        state <= HI;
                    end
                end
                HI: begin
                    if (ready) begin
                        ctrl  <= mem[rd_ptr][15:0];
                        state <= LO;
                    end
                end
                LO: begin
                    if (ready) begin
                        if (more_after_pop) begin
                            ctrl  <= next_hi;
                            state <= HI;
                        end else begin
                            req   <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    req   <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            illegal_cnt <= '0;
        end else if (accept && is_illegal && (illegal_cnt != '1)) begin
            illegal_cnt <= illegal_cnt + CNT_W'(1);
        end
    end

    // Set has priority over clear so an edge coinciding with a clear is kept.
    assign rise = alarm_in & ~alarm_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            alarm_q   <= '0;
            alarm_evt <= '0;
        end else begin
            alarm_q   <= alarm_in;
            alarm_evt <= (alarm_evt & ~alarm_clr) | rise;
        end
    end

endmodule
